// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory access arbiter: FSM state encoding,
// requester identifiers and the data-versus-fetch priority rule.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SETUP = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } arb_state_t;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

    // Data normally wins; fetch wins only once the data run has used up its allowance.
    function automatic logic pick_winner(input logic if_req, input logic d_req,
                                         input logic fetch_due);
        return (d_req && !(fetch_due && if_req)) ? REQ_DATA : REQ_FETCH;
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Priority pick between fetch and data requesters, with the run counter that
// bounds how many data grants may pass a waiting fetch.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_RUN = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic if_req,
    input  logic d_req,
    input  logic grant_take,
    output logic grant_valid,
    output logic grant_id
);

    localparam int RUN_W = (MAX_DATA_RUN < 1) ? 1 : $clog2(MAX_DATA_RUN + 1);

    logic [RUN_W-1:0] run_cnt;
    logic             fetch_due;

    assign fetch_due   = (run_cnt == RUN_W'(MAX_DATA_RUN));
    assign grant_valid = if_req | d_req;
    assign grant_id    = pick_winner(if_req, d_req, fetch_due);

    // Only data grants that actually bypass a pending fetch count against the run.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            run_cnt <= '0;
        end else if (grant_take && grant_valid) begin
            if (grant_id == REQ_FETCH)
                run_cnt <= '0;
            else if (if_req)
                run_cnt <= run_cnt + RUN_W'(1);
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates the shared RAM port between fetch and load/store and runs the
// MOV/MOC handshake. Optional WAIT timeout with sticky err: MEM_TIMEOUT_EN.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_DATA_RUN = 2
`ifdef MEM_TIMEOUT_EN
    , parameter int TIMEOUT    = 15
`endif
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              R_W,
    output logic              MOV,
    input  logic              MOC,
    output logic              busy,
    output logic              err
);

    arb_state_t state;
    logic       winner;
    logic       grant_valid;
    logic       grant_id;

`ifdef MEM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] wait_cnt;
`else
    assign err = 1'b0;
`endif

    mem_arb_prio #(
        .MAX_DATA_RUN(MAX_DATA_RUN)
    ) u_prio (
        .clk        (clk),
        .clr        (clr),
        .if_req     (if_req),
        .d_req      (d_req),
        .grant_take (state == IDLE),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    assign busy = (state != IDLE);

    // Requests are latched at grant so requesters may change inputs freely afterwards.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            winner    <= REQ_FETCH;
            MOV       <= 1'b0;
            R_W       <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt  <= '0;
            err       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        winner <= grant_id;
                        state  <= SETUP;
                        if (grant_id == REQ_DATA) begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            R_W       <= ~d_we;
                        end else begin
                            mem_addr <= if_addr;
                            R_W      <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    MOV   <= 1'b1;
                    state <= WAIT;
`ifdef MEM_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (MOC) begin
                        MOV     <= 1'b0;
                        state   <= DONE;
                        if_done <= (winner == REQ_FETCH);
                        d_done  <= (winner == REQ_DATA);
                        if (R_W && winner == REQ_FETCH)
                            if_rdata <= mem_rdata;
                        if (R_W && winner == REQ_DATA)
                            d_rdata <= mem_rdata;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
                        MOV     <= 1'b0;
                        state   <= DONE;
                        if_done <= (winner == REQ_FETCH);
                        d_done  <= (winner == REQ_DATA);
                        err     <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
`endif
                end
                DONE: begin
                    if_done <= 1'b0;
                    d_done  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: transaction-level model plus a
// small RAM responder with programmable MOC delay; timeout cases under MEM_TIMEOUT_EN.
module tb_mem_access_arbiter;

    localparam int MAX_RUN     = 2;
    localparam int TIMEOUT_CYC = 15;

    logic        clk = 1'b0;
    logic        clr;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_done;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        R_W;
    logic        MOV;
    logic        MOC;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MAX_DATA_RUN(MAX_RUN)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .R_W      (R_W),
        .MOV      (MOV),
        .MOC      (MOC),
        .busy     (busy),
        .err      (err)
    );

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return (a == 32'h10) ? 32'hE3A01005 : (a ^ 32'hA5A50000);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h at %0t", name, got, want, $time);
        end
    endtask

    task automatic applyStimulus(input logic i_req, input logic [31:0] i_addr,
                                 input logic dr, input logic dwe,
                                 input logic [31:0] da, input logic [31:0] dwd);
        if_req  = i_req;
        if_addr = i_addr;
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
    endtask

    // RAM responder: asserts MOC after moc_delay cycles of MOV (0 = never).
    int   moc_delay = 1;
    int   wait_seen = 0;
    logic moc_resp  = 1'b0;
    logic moc_stray = 1'b0;
    assign MOC = moc_resp | moc_stray;

    always @(negedge clk) begin
        mem_rdata = ram_word(mem_addr);
        if (MOV) begin
            wait_seen++;
            moc_resp = (moc_delay > 0) && (wait_seen >= moc_delay);
        end else begin
            wait_seen = 0;
            moc_resp  = 1'b0;
        end
    end

    // Transaction model: m_age 0 = setup cycle, 1 = waiting for MOC, 2 = done cycle.
    logic        m_busy = 1'b0;
    int          m_age = 0;
    logic        m_who = 1'b0;
    logic        m_rw = 1'b1;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic        m_if_done = 1'b0;
    logic        m_d_done = 1'b0;
    logic [31:0] m_if_rdata = '0;
    logic [31:0] m_d_rdata = '0;
    int          m_run = 0;
    int          m_wait = 0;
    logic        m_err = 1'b0;
    logic        m_finish;
    int          m_grants[$];

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_busy = 1'b0; m_age = 0; m_rw = 1'b1; m_addr = '0;
            m_if_done = 1'b0; m_d_done = 1'b0;
            m_if_rdata = '0; m_d_rdata = '0; m_run = 0; m_err = 1'b0;
        end else begin
            m_if_done = 1'b0;
            m_d_done  = 1'b0;
            m_finish  = 1'b0;
            if (!m_busy) begin
                if (if_req || d_req) begin
                    m_who = (d_req && !(m_run == MAX_RUN && if_req));
                    if (m_who) begin
                        m_addr  = d_addr;
                        m_wdata = d_wdata;
                        m_rw    = !d_we;
                        if (if_req) m_run++;
                    end else begin
                        m_addr = if_addr;
                        m_rw   = 1'b1;
                        m_run  = 0;
                    end
                    m_grants.push_back(int'(m_who));
                    m_busy = 1'b1;
                    m_age  = 0;
                end
            end else if (m_age == 0) begin
                m_age  = 1;
                m_wait = 0;
            end else if (m_age == 1) begin
                if (MOC) begin
                    m_finish = 1'b1;
                    if (m_rw && !m_who) m_if_rdata = ram_word(m_addr);
                    if (m_rw && m_who)  m_d_rdata  = ram_word(m_addr);
                end else begin
                    m_wait++;
`ifdef MEM_TIMEOUT_EN
                    if (m_wait == TIMEOUT_CYC) begin
                        m_finish = 1'b1;
                        m_err    = 1'b1;
                    end
`endif
                end
                if (m_finish) begin
                    m_age     = 2;
                    m_if_done = !m_who;
                    m_d_done  = m_who;
                end
            end else begin
                m_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (clr === 1'b1) begin
            checkOutput("busy", busy, m_busy);
            checkOutput("MOV", MOV, m_busy && m_age == 1);
            checkOutput("R_W", R_W, m_rw);
            checkOutput("mem_addr", mem_addr, m_addr);
            if (m_busy && !m_rw) checkOutput("mem_wdata", mem_wdata, m_wdata);
            checkOutput("if_done", if_done, m_if_done);
            checkOutput("d_done", d_done, m_d_done);
            checkOutput("if_rdata", if_rdata, m_if_rdata);
            checkOutput("d_rdata", d_rdata, m_d_rdata);
            checkOutput("err", err, m_err);
        end
    end

    task automatic waitDone(input int budget, output int cycles, output logic was_data);
        cycles   = 0;
        was_data = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (if_done || d_done) begin
                cycles   = i;
                was_data = d_done;
                return;
            end
        end
        checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    int   cyc;
    logic wd;
    int   order[6];
    int   exp_order[6];
    int   mov_cycles;
    int   last_mov;
    int   done_at;

    initial begin
        exp_order = '{1, 1, 0, 1, 1, 0};

        // Reset held with a pending fetch: nothing may start.
        clr = 1'b0;
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        checkOutput("rst_MOV", MOV, 32'd0);
        checkOutput("rst_busy", busy, 32'd0);
        checkOutput("rst_R_W", R_W, 32'd1);
        checkOutput("rst_if_done", if_done, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        clr = 1'b1;
        waitDone(20, cyc, wd);
        checkOutput("fetch_latency", cyc, 32'd3);
        checkOutput("fetch_is_if", wd, 32'd0);
        checkOutput("fetch_rdata", if_rdata, 32'hE3A01005);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);

        // Store
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF);
        repeat (2) @(negedge clk);
        checkOutput("store_MOV", MOV, 32'd1);
        checkOutput("store_R_W", R_W, 32'd0);
        checkOutput("store_addr", mem_addr, 32'h20);
        checkOutput("store_wdata", mem_wdata, 32'hDEADBEEF);
        waitDone(20, cyc, wd);
        checkOutput("store_is_d", wd, 32'd1);
        checkOutput("store_d_rdata", d_rdata, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("store_single_done", d_done, 32'd0);

        // Contention: both requesters held throughout
        m_grants.delete();
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0);
        for (int k = 0; k < 6; k++) begin
            waitDone(20, cyc, wd);
            order[k] = int'(wd);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            checkOutput("grant_order_dut", order[k], exp_order[k]);
            if (k < m_grants.size())
                checkOutput("grant_order_model", m_grants[k], exp_order[k]);
        end
        checkOutput("grant_count_model", m_grants.size(), 32'd6);
        checkOutput("contention_if_rdata", if_rdata, 32'hA5A50100);
        checkOutput("contention_d_rdata", d_rdata, 32'hA5A50200);
        @(negedge clk);

        // MOC stall of 10 cycles on a load
        moc_delay = 10;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
        mov_cycles = 0; last_mov = 0; done_at = 0;
        for (int i = 1; i <= 40 && done_at == 0; i++) begin
            @(negedge clk);
            if (MOV) begin mov_cycles++; last_mov = i; end
            if (d_done) done_at = i;
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("stall_mov_cycles", mov_cycles, 32'd10);
        checkOutput("stall_done_gap", done_at - last_mov, 32'd1);
        checkOutput("stall_d_rdata", d_rdata, 32'hA5A50040);
        moc_delay = 1;
        @(negedge clk);

        // Stray MOC while idle
        moc_stray = 1'b1;
        @(negedge clk);
        moc_stray = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("stray_busy", busy, 32'd0);
        checkOutput("stray_MOV", MOV, 32'd0);

        // Reset in the middle of WAIT
        moc_delay = 0;
        applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        checkOutput("midrst_MOV_before", MOV, 32'd1);
        #2 clr = 1'b0;
        #1;
        checkOutput("midrst_MOV", MOV, 32'd0);
        checkOutput("midrst_busy", busy, 32'd0);
        checkOutput("midrst_if_done", if_done, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        #2 clr = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("midrst_idle", busy, 32'd0);
        checkOutput("midrst_no_done", if_done, 32'd0);
        moc_delay = 1;

`ifdef MEM_TIMEOUT_EN
        // MOC never arrives: access aborts after TIMEOUT WAIT cycles
        moc_delay = 0;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h50, 32'h0);
        mov_cycles = 0; done_at = 0;
        for (int i = 1; i <= 60 && done_at == 0; i++) begin
            @(negedge clk);
            if (MOV) mov_cycles++;
            if (d_done) done_at = i;
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("to_mov_cycles", mov_cycles, 32'd15);
        checkOutput("to_done_seen", done_at != 0, 32'd1);
        checkOutput("to_err", err, 32'd1);
        checkOutput("to_d_rdata", d_rdata, 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("to_err_sticky", err, 32'd1);
        #2 clr = 1'b0;
        #1;
        checkOutput("to_err_cleared", err, 32'd0);
        @(negedge clk);
        #2 clr = 1'b1;
        moc_delay = 1;
        repeat (2) @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
